baby_sequencer: RTL and testbench
=================================

Name: baby_sequencer

Overview:
- Control sequencer for the Manchester Baby datapath.
- Sequences the 32-bit latch registers CI, PI, ACC and MDR, the ALU and the store over the shared data bus.
- Generates the active-high latch-enable strobes and active-low output enables.
- Guarantees at most one bus driver at any time and runs the INC/FETCH/DECODE/OPERAND/EXEC cycle per instruction.

Parameters:
HOLD_CYCLES, 1, cycles a bus source stays driven after its LE/WE strobe falls (legal 1..3)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; leaves HALT
step_mode  input  1  1 = return to HALT after each instruction
stop_req  input  1  level; halt at next instruction boundary
func  input  3  PI[15:13] function field (0 JMP,1 JRP,2 LDN,3 STO,4/5 SUB,6 CMP,7 STP)
acc_sign  input  1  ACC[31]
ci_le, pi_le, acc_le, mdr_le  output  1 each  latch enables, active high
acc_oe_n, alu_oe_n, mem_oe_n  output  1 each  bus driver enables, active low
mem_we  output  1  store write strobe, active high
mar_sel  output  1  store address source: 0 = CI[4:0], 1 = PI[4:0]
alu_a_sel  output  1  ALU A operand: 0 = CI, 1 = ACC (B operand is always MDR)
alu_op  output  3  0 INC(A+1), 1 ADD(A+B), 2 NEG(0-B), 3 SUB(A-B), 4 PASS_B
halted  output  1  1 while in HALT
state_dbg  output  4  current state encoding

Behaviour:
Reset and output timing:
- All outputs come from flops; no combinational path from inputs to outputs.
- On reset: state HALT, halted=1, all LE and mem_we low, all OE_n high, mar_sel=0, alu_a_sel=0, alu_op=0.
- Reset during a transfer: strobes drop and drivers release on the same edge.

Transfers:
- A transfer is STROBE (1 cycle: source driven, LE/WE high) followed by HOLD (HOLD_CYCLES cycles: source still driven, LE/WE low).
- Selects (mar_sel, alu_a_sel, alu_op) are constant across the whole transfer.
- Invariant: never more than one of acc_oe_n/alu_oe_n/mem_oe_n low.
- Invariant: never more than one LE/WE high.
- Invariant: no LE high without a bus source driven.

States:
- HALT: idle. start → INC_S. start is ignored outside HALT.
- INC: a_sel=CI, INC, alu_oe_n=0, ci_le strobe → FETCH.
- FETCH: mar_sel=0, mem_oe_n=0, pi_le strobe → DECODE.
- DECODE: one cycle, no drivers, samples func.
  - JMP/JRP/LDN/SUB → OPERAND.
  - STO → EXEC_STO.
  - CMP with acc_sign=1 → EXEC_SKIP.
  - CMP with acc_sign=0 → END.
  - STP → HALT, with STP treated as an instruction boundary.
- OPERAND: mar_sel=1, mem_oe_n=0, mdr_le strobe → EXEC.
- EXEC (alu_oe_n=0 throughout), then → END:
  - JMP: PASS_B, ci_le.
  - JRP: a_sel=CI, ADD, ci_le.
  - LDN: NEG, acc_le.
  - SUB: a_sel=ACC, SUB, acc_le.
- EXEC_STO: mar_sel=1, acc_oe_n=0, mem_we strobe → END.
- EXEC_SKIP: same signals as INC → END.
- END: zero-cycle decision folded into the last HOLD cycle. step_mode=1 or stop_req=1 → HALT, else → INC_S.

Latencies (HOLD_CYCLES=1):
- start sampled at edge k → INC strobe visible after edge k+1.
- Instruction lengths: JMP/JRP/LDN/SUB 9 cycles; STO 7; CMP taken 7; CMP not taken 5; STP 5, then halted.
- Each extra HOLD cycle adds 1 cycle per transfer.
- halted rises on the edge entering HALT.
- start asserted the same cycle as the final HOLD is ignored.

Test Plan:
- Reset mid-EXEC of SUB (acc_le=1, alu_oe_n=0): assert reset 1 cycle → next cycle all LE 0, all OE_n 1, halted=1, state_dbg=HALT.
- start, func=1 (JRP), step_mode=1: strobe sequence ci_le, pi_le, mdr_le, ci_le on cycles 1, 3, 6, 8 relative to the first INC cycle; alu_op INC, -, -, ADD with a_sel=CI; halted=1 after 9 cycles.
- func=6, acc_sign=1 → two ci_le strobes (INC, SKIP), 7 cycles; repeat with acc_sign=0 → one ci_le, 5 cycles, no mdr_le.
- func=3 (STO): mem_we high exactly 1 cycle with mar_sel=1 and acc_oe_n=0 for 2 cycles; mem_oe_n stays high during the write.
- Free-run, step_mode=0, program JMP, LDN, SUB, STP: halted after STP DECODE; scoreboard checks the single-driver and LE-only-with-driver invariants every cycle.
- HOLD_CYCLES=3, stop_req raised mid-LDN: each driver stays low 3 cycles after its LE falls; the LDN instruction takes 17 cycles; halts at the instruction end, not mid-instruction.

Source files
------------

// File: rtl/baby_sequencer.sv
// ============================================================================
// baby_sequencer
// ----------------------------------------------------------------------------
// Control sequencer for the Manchester Baby datapath. It walks each
// instruction through INC / FETCH / DECODE / OPERAND / EXEC. While doing so it
// drives the latch strobes for CI, PI, ACC and MDR, the store write strobe and
// the enables for the shared data bus.
//
// Every bus movement is a transfer with two parts:
//   - STROBE: one cycle with the source driven and the LE/WE high.
//   - HOLD:   HOLD_CYCLES cycles with the source still driven and the LE/WE low.
// Only one source ever drives the bus, and no strobe is raised without a
// driver. All outputs are registered, so no input reaches an output
// combinationally.
//
// Parameters:
//   HOLD_CYCLES  cycles a source stays driven after its strobe falls (1..3)
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse, leaves HALT (ignored elsewhere)
//   step_mode  1 = return to HALT after every instruction
//   stop_req   level, halt at the next instruction boundary
//   func       PI[15:13] function field
//   acc_sign   ACC[31], used by CMP
//   ci_le, pi_le, acc_le, mdr_le   latch enables, active high
//   acc_oe_n, alu_oe_n, mem_oe_n   bus driver enables, active low
//   mem_we     store write strobe, active high
//   mar_sel    store address source: 0 = CI[4:0], 1 = PI[4:0]
//   alu_a_sel  ALU A operand: 0 = CI, 1 = ACC
//   alu_op     0 INC, 1 ADD, 2 NEG, 3 SUB, 4 PASS_B
//   halted     high while in HALT
//   state_dbg  current state encoding
// ============================================================================
module baby_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step_mode,
    input  logic       stop_req,
    input  logic [2:0] func,
    input  logic       acc_sign,
    output logic       ci_le,
    output logic       pi_le,
    output logic       acc_le,
    output logic       mdr_le,
    output logic       acc_oe_n,
    output logic       alu_oe_n,
    output logic       mem_oe_n,
    output logic       mem_we,
    output logic       mar_sel,
    output logic       alu_a_sel,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic [3:0] state_dbg
);

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_NEG  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_PASS = 3'd4;

    localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

    typedef enum logic [3:0] {
        HALT    = 4'd0,
        INC_S   = 4'd1,
        INC_H   = 4'd2,
        FETCH_S = 4'd3,
        FETCH_H = 4'd4,
        DECODE  = 4'd5,
        OPER_S  = 4'd6,
        OPER_H  = 4'd7,
        EXEC_S  = 4'd8,
        EXEC_H  = 4'd9,
        STO_S   = 4'd10,
        STO_H   = 4'd11,
        SKIP_S  = 4'd12,
        SKIP_H  = 4'd13
    } state_t;

    state_t     state;
    state_t     next_state;
    state_t     boundary_next;
    logic [1:0] hold_cnt;
    logic       hold_last;
    logic       in_hold;
    logic       start_q;
    logic [2:0] func_q;

    logic       n_ci_le, n_pi_le, n_acc_le, n_mdr_le, n_mem_we;
    logic       n_acc_oe_n, n_alu_oe_n, n_mem_oe_n;
    logic       n_mar_sel, n_alu_a_sel, n_halted;
    logic [2:0] n_alu_op;

    // Next-state logic. The instruction boundary ("END") takes no cycle of its
    // own. Its decision is made in the last HOLD cycle, or in DECODE for the
    // CMP-not-taken case.
    always_comb begin
        next_state    = state;
        in_hold       = 1'b0;
        hold_last     = (hold_cnt == HOLD_LAST);
        boundary_next = (step_mode || stop_req) ? HALT : INC_S;

        case (state)
            INC_H, FETCH_H, OPER_H, EXEC_H, STO_H, SKIP_H: in_hold = 1'b1;
            default: in_hold = 1'b0;
        endcase

        case (state)
            HALT:    if (start_q) next_state = INC_S;
            INC_S:   next_state = INC_H;
            INC_H:   if (hold_last) next_state = FETCH_S;
            FETCH_S: next_state = FETCH_H;
            FETCH_H: if (hold_last) next_state = DECODE;
            DECODE: begin
                case (func)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: next_state = OPER_S;
                    3'd3:    next_state = STO_S;
                    3'd6:    next_state = acc_sign ? SKIP_S : boundary_next;
                    default: next_state = HALT;
                endcase
            end
            OPER_S:  next_state = OPER_H;
            OPER_H:  if (hold_last) next_state = EXEC_S;
            EXEC_S:  next_state = EXEC_H;
            EXEC_H:  if (hold_last) next_state = boundary_next;
            STO_S:   next_state = STO_H;
            STO_H:   if (hold_last) next_state = boundary_next;
            SKIP_S:  next_state = SKIP_H;
            SKIP_H:  if (hold_last) next_state = boundary_next;
            default: next_state = HALT;
        endcase
    end

    // The outputs are decoded from the state being entered and registered
    // alongside it, so they line up with the state without any input-to-output
    // combinational path. func_q is stable long before EXEC is entered.
    always_comb begin
        n_ci_le     = 1'b0;
        n_pi_le     = 1'b0;
        n_acc_le    = 1'b0;
        n_mdr_le    = 1'b0;
        n_mem_we    = 1'b0;
        n_acc_oe_n  = 1'b1;
        n_alu_oe_n  = 1'b1;
        n_mem_oe_n  = 1'b1;
        n_mar_sel   = 1'b0;
        n_alu_a_sel = 1'b0;
        n_alu_op    = OP_INC;
        n_halted    = (next_state == HALT);

        case (next_state)
            INC_S, SKIP_S: begin
                n_ci_le    = 1'b1;
                n_alu_oe_n = 1'b0;
            end
            INC_H, SKIP_H: n_alu_oe_n = 1'b0;
            FETCH_S: begin
                n_pi_le    = 1'b1;
                n_mem_oe_n = 1'b0;
            end
            FETCH_H: n_mem_oe_n = 1'b0;
            OPER_S: begin
                n_mdr_le   = 1'b1;
                n_mar_sel  = 1'b1;
                n_mem_oe_n = 1'b0;
            end
            OPER_H: begin
                n_mar_sel  = 1'b1;
                n_mem_oe_n = 1'b0;
            end
            EXEC_S, EXEC_H: begin
                n_alu_oe_n = 1'b0;
                case (func_q)
                    3'd0: begin
                        n_alu_op = OP_PASS;
                        n_ci_le  = (next_state == EXEC_S);
                    end
                    3'd1: begin
                        n_alu_op = OP_ADD;
                        n_ci_le  = (next_state == EXEC_S);
                    end
                    3'd2: begin
                        n_alu_op = OP_NEG;
                        n_acc_le = (next_state == EXEC_S);
                    end
                    3'd4, 3'd5: begin
                        n_alu_op    = OP_SUB;
                        n_alu_a_sel = 1'b1;
                        n_acc_le    = (next_state == EXEC_S);
                    end
                    default: n_alu_oe_n = 1'b1;
                endcase
            end
            STO_S: begin
                n_mem_we   = 1'b1;
                n_mar_sel  = 1'b1;
                n_acc_oe_n = 1'b0;
            end
            STO_H: begin
                n_mar_sel  = 1'b1;
                n_acc_oe_n = 1'b0;
            end
            default: ;
        endcase
    end

    // State, hold counter, start capture and the registered outputs.
    // start is captured only in HALT, so a pulse that arrives during an
    // instruction's last HOLD cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HALT;
            hold_cnt  <= 2'd0;
            start_q   <= 1'b0;
            func_q    <= 3'd0;
            ci_le     <= 1'b0;
            pi_le     <= 1'b0;
            acc_le    <= 1'b0;
            mdr_le    <= 1'b0;
            mem_we    <= 1'b0;
            acc_oe_n  <= 1'b1;
            alu_oe_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mar_sel   <= 1'b0;
            alu_a_sel <= 1'b0;
            alu_op    <= OP_INC;
            halted    <= 1'b1;
        end else begin
            state     <= next_state;
            hold_cnt  <= (in_hold && !hold_last) ? hold_cnt + 2'd1 : 2'd0;
            start_q   <= start && (state == HALT);
            if (state == DECODE) func_q <= func;
            ci_le     <= n_ci_le;
            pi_le     <= n_pi_le;
            acc_le    <= n_acc_le;
            mdr_le    <= n_mdr_le;
            mem_we    <= n_mem_we;
            acc_oe_n  <= n_acc_oe_n;
            alu_oe_n  <= n_alu_oe_n;
            mem_oe_n  <= n_mem_oe_n;
            mar_sel   <= n_mar_sel;
            alu_a_sel <= n_alu_a_sel;
            alu_op    <= n_alu_op;
            halted    <= n_halted;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_baby_sequencer.sv
// ============================================================================
// tb_baby_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for baby_sequencer. It drives two instances from the
// same inputs: HOLD_CYCLES=1 (d1_*) and HOLD_CYCLES=3 (d3_*).
// A table of single-step instructions checks lengths, strobe counts and the
// ALU selects on the final strobe. Hand-written sequences cover the cycle-exact
// corner cases. A negedge monitor checks the bus invariants on both instances.
// ============================================================================
module tb_baby_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, step_mode, stop_req, acc_sign;
    logic [2:0] func;

    logic       d1_ci_le, d1_pi_le, d1_acc_le, d1_mdr_le, d1_acc_oe_n, d1_alu_oe_n;
    logic       d1_mem_oe_n, d1_mem_we, d1_mar_sel, d1_alu_a_sel, d1_halted;
    logic [2:0] d1_alu_op;
    logic [3:0] d1_state_dbg;
    logic       d3_ci_le, d3_pi_le, d3_acc_le, d3_mdr_le, d3_acc_oe_n, d3_alu_oe_n;
    logic       d3_mem_oe_n, d3_mem_we, d3_mar_sel, d3_alu_a_sel, d3_halted;
    logic [2:0] d3_alu_op;
    logic [3:0] d3_state_dbg;

    baby_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .stop_req(stop_req), .func(func), .acc_sign(acc_sign),
        .ci_le(d1_ci_le), .pi_le(d1_pi_le), .acc_le(d1_acc_le), .mdr_le(d1_mdr_le),
        .acc_oe_n(d1_acc_oe_n), .alu_oe_n(d1_alu_oe_n), .mem_oe_n(d1_mem_oe_n),
        .mem_we(d1_mem_we), .mar_sel(d1_mar_sel), .alu_a_sel(d1_alu_a_sel),
        .alu_op(d1_alu_op), .halted(d1_halted), .state_dbg(d1_state_dbg)
    );

    baby_sequencer #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .stop_req(stop_req), .func(func), .acc_sign(acc_sign),
        .ci_le(d3_ci_le), .pi_le(d3_pi_le), .acc_le(d3_acc_le), .mdr_le(d3_mdr_le),
        .acc_oe_n(d3_acc_oe_n), .alu_oe_n(d3_alu_oe_n), .mem_oe_n(d3_mem_oe_n),
        .mem_we(d3_mem_we), .mar_sel(d3_mar_sel), .alu_a_sel(d3_alu_a_sel),
        .alu_op(d3_alu_op), .halted(d3_halted), .state_dbg(d3_state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit mon_on = 1'b0;

    // Packed output word:
    //   [17:13] {ci,pi,acc,mdr,we}   [12:10] {acc_oe_n,alu_oe_n,mem_oe_n}
    //   [9] mar_sel  [8] alu_a_sel  [7:5] alu_op  [4] halted  [3:0] state_dbg
    logic [17:0] tr_log [0:63];
    int          tr_len;

    typedef struct {
        logic [2:0] f;
        logic       sign;
        int         len;
        int         n_ci, n_pi, n_acc, n_mdr, n_we;
        bit         chk_sel;
        logic [3:0] last_sel;
    } vec_t;

    vec_t tbl [0:8];

    function automatic logic [17:0] packOut(input bit sel3);
        if (sel3)
            return {d3_ci_le, d3_pi_le, d3_acc_le, d3_mdr_le, d3_mem_we,
                    d3_acc_oe_n, d3_alu_oe_n, d3_mem_oe_n, d3_mar_sel,
                    d3_alu_a_sel, d3_alu_op, d3_halted, d3_state_dbg};
        return {d1_ci_le, d1_pi_le, d1_acc_le, d1_mdr_le, d1_mem_we,
                d1_acc_oe_n, d1_alu_oe_n, d1_mem_oe_n, d1_mar_sel,
                d1_alu_a_sel, d1_alu_op, d1_halted, d1_state_dbg};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int countBit(input int b);
        int c = 0;
        for (int i = 1; i <= tr_len; i++) if (tr_log[i][b]) c++;
        return c;
    endfunction

    function automatic logic [2:0] progFunc(input int n);
        if (n <= 9)  return 3'd0;
        if (n <= 18) return 3'd2;
        if (n <= 27) return 3'd4;
        return 3'd7;
    endfunction

    // Pulse start and record every non-halted cycle into tr_log[1..].
    // prog drives a JMP/LDN/SUB/STP program through func. stop_at and
    // start_at raise stop_req or start after the given cycle.
    task automatic applyStimulus(input bit sel3, input bit prog, input int stop_at,
                                 input int start_at, input int budget);
        logic [17:0] p;
        start = 1'b1;
        tick();
        start = 1'b0;
        p = packOut(sel3);
        checkOutput("start_latency_halted", int'(p[4]), 1);
        tr_len = 0;
        for (int n = 1; n <= budget; n++) begin
            tick();
            p = packOut(sel3);
            if (p[4]) break;
            tr_log[n] = p;
            tr_len    = n;
            if (prog) func = progFunc(n);
            if (n == stop_at) stop_req = 1'b1;
            if (n == start_at) start = 1'b1;
        end
        if (!p[4]) checkOutput("timeout", 0, 1);
        start    = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic checkInv(input bit sel3);
        logic [17:0] p;
        int drv, stb;
        p   = packOut(sel3);
        drv = int'(!p[12]) + int'(!p[11]) + int'(!p[10]);
        stb = int'(p[17]) + int'(p[16]) + int'(p[15]) + int'(p[14]) + int'(p[13]);
        checkOutput(sel3 ? "invariant_hold3" : "invariant_hold1",
                    int'(drv <= 1 && stb <= 1 && (stb == 0 || drv == 1)), 1);
    endtask

    // Every cycle: at most one driver, at most one strobe, and no strobe
    // without a driver.
    always @(negedge clk) begin
        if (mon_on) begin
            checkInv(1'b0);
            checkInv(1'b1);
        end
    end

    logic [7:0] jrp_exp [1:9];
    logic [7:0] ldn3_exp [1:17];

    initial begin
        logic [17:0] p;
        int          last;

        tbl[0] = '{3'd0, 1'b0, 9, 2, 1, 0, 1, 0, 1'b1, 4'b0100};
        tbl[1] = '{3'd1, 1'b0, 9, 2, 1, 0, 1, 0, 1'b1, 4'b0001};
        tbl[2] = '{3'd2, 1'b0, 9, 1, 1, 1, 1, 0, 1'b1, 4'b0010};
        tbl[3] = '{3'd3, 1'b0, 7, 1, 1, 0, 0, 1, 1'b0, 4'b0000};
        tbl[4] = '{3'd4, 1'b0, 9, 1, 1, 1, 1, 0, 1'b1, 4'b1011};
        tbl[5] = '{3'd5, 1'b1, 9, 1, 1, 1, 1, 0, 1'b1, 4'b1011};
        tbl[6] = '{3'd6, 1'b1, 7, 2, 1, 0, 0, 0, 1'b1, 4'b0000};
        tbl[7] = '{3'd6, 1'b0, 5, 1, 1, 0, 0, 0, 1'b0, 4'b0000};
        tbl[8] = '{3'd7, 1'b0, 5, 1, 1, 0, 0, 0, 1'b0, 4'b0000};

        jrp_exp[1] = 8'b10000_101;
        jrp_exp[2] = 8'b00000_101;
        jrp_exp[3] = 8'b01000_110;
        jrp_exp[4] = 8'b00000_110;
        jrp_exp[5] = 8'b00000_111;
        jrp_exp[6] = 8'b00010_110;
        jrp_exp[7] = 8'b00000_110;
        jrp_exp[8] = 8'b10000_101;
        jrp_exp[9] = 8'b00000_101;

        for (int i = 1; i <= 17; i++) begin
            logic [2:0] oe;
            logic [4:0] stb;
            if (i <= 4)       oe = 3'b101;
            else if (i <= 8)  oe = 3'b110;
            else if (i == 9)  oe = 3'b111;
            else if (i <= 13) oe = 3'b110;
            else              oe = 3'b101;
            case (i)
                1:       stb = 5'b10000;
                5:       stb = 5'b01000;
                10:      stb = 5'b00010;
                14:      stb = 5'b00100;
                default: stb = 5'b00000;
            endcase
            ldn3_exp[i] = {stb, oe};
        end

        reset = 1'b1; start = 1'b0; step_mode = 1'b1; stop_req = 1'b0;
        func = 3'd0; acc_sign = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        mon_on = 1'b1;

        // Reset state (state_dbg excluded)
        p = packOut(1'b0);
        checkOutput("reset_state_h1", int'(p[17:4]), int'(14'b00000_111_0_0_000_1));
        p = packOut(1'b1);
        checkOutput("reset_state_h3", int'(p[17:4]), int'(14'b00000_111_0_0_000_1));

        // Table of single-step instructions on the HOLD_CYCLES=1 instance
        for (int v = 0; v < 9; v++) begin
            func     = tbl[v].f;
            acc_sign = tbl[v].sign;
            applyStimulus(1'b0, 1'b0, 0, 0, 40);
            checkOutput($sformatf("len_f%0d_s%0d", tbl[v].f, tbl[v].sign), tr_len, tbl[v].len);
            checkOutput($sformatf("ci_le_f%0d", tbl[v].f),  countBit(17), tbl[v].n_ci);
            checkOutput($sformatf("pi_le_f%0d", tbl[v].f),  countBit(16), tbl[v].n_pi);
            checkOutput($sformatf("acc_le_f%0d", tbl[v].f), countBit(15), tbl[v].n_acc);
            checkOutput($sformatf("mdr_le_f%0d", tbl[v].f), countBit(14), tbl[v].n_mdr);
            checkOutput($sformatf("mem_we_f%0d", tbl[v].f), countBit(13), tbl[v].n_we);
            if (tbl[v].chk_sel) begin
                last = 0;
                for (int i = 1; i <= tr_len; i++) if (tr_log[i][17:13] != 5'd0) last = i;
                checkOutput($sformatf("exec_sel_f%0d", tbl[v].f),
                            int'(tr_log[last][8:5]), int'(tbl[v].last_sel));
            end
        end

        // JRP cycle-exact strobes and drivers
        pulseReset();
        func = 3'd1; acc_sign = 1'b0; step_mode = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0, 40);
        checkOutput("jrp_len", tr_len, 9);
        for (int i = 1; i <= 9; i++)
            checkOutput($sformatf("jrp_cycle%0d", i), int'(tr_log[i][17:10]), int'(jrp_exp[i]));
        checkOutput("jrp_inc_sel", int'(tr_log[1][8:5]), int'(4'b0000));
        checkOutput("jrp_add_sel", int'(tr_log[8][8:5]), int'(4'b0001));

        // STO: one write cycle, ACC drives for two cycles with mar_sel=1
        func = 3'd3;
        applyStimulus(1'b0, 1'b0, 0, 0, 40);
        last = 0;
        for (int i = 1; i <= tr_len; i++) if (!tr_log[i][12] && tr_log[i][9]) last++;
        checkOutput("sto_acc_drive_mar1", last, 2);
        checkOutput("sto_acc_drive_total", 12 - countBit(12) - (12 - tr_len), 2);
        checkOutput("sto_we_cycle6", int'(tr_log[6][13]), 1);
        checkOutput("sto_mem_oe_n_at_we", int'(tr_log[6][10]), 1);

        // start during the final HOLD cycle of JMP is dropped
        func = 3'd0;
        applyStimulus(1'b0, 1'b0, 0, 9, 40);
        checkOutput("late_start_len", tr_len, 9);
        tick(); tick(); tick();
        p = packOut(1'b0);
        checkOutput("late_start_still_halted", int'({p[17], p[4]}), 1);

        // Reset in the middle of SUB's EXEC strobe
        func = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        p = packOut(1'b0);
        checkOutput("sub_exec_acc_le_alu", int'({p[15], p[11]}), int'(2'b10));
        pulseReset();
        p = packOut(1'b0);
        checkOutput("reset_mid_sub", int'(p[17:4]), int'(14'b00000_111_0_0_000_1));

        // Free-running program JMP, LDN, SUB, STP
        pulseReset();
        step_mode = 1'b0;
        func = 3'd0;
        applyStimulus(1'b0, 1'b1, 0, 0, 60);
        checkOutput("prog_len", tr_len, 32);
        checkOutput("prog_ci_le", countBit(17), 5);
        checkOutput("prog_pi_le", countBit(16), 4);
        checkOutput("prog_acc_le", countBit(15), 2);
        checkOutput("prog_mdr_le", countBit(14), 3);

        // HOLD_CYCLES=3, LDN free-running with stop_req raised mid-instruction
        pulseReset();
        step_mode = 1'b0;
        func = 3'd2;
        applyStimulus(1'b1, 1'b0, 8, 0, 60);
        checkOutput("hold3_ldn_len", tr_len, 17);
        for (int i = 1; i <= 17; i++)
            checkOutput($sformatf("hold3_cycle%0d", i), int'(tr_log[i][17:10]), int'(ldn3_exp[i]));
        tick(); tick();
        p = packOut(1'b1);
        checkOutput("hold3_stays_halted", int'(p[4]), 1);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
